// File: rtl/frame_deserializer.sv
// Frame deserializer: hunts for a header byte, collects NUM_CHANNELS payload
// bytes into a staging buffer, and publishes them only when the footer byte
// matches. Footer mismatches are counted, and a header in the footer slot
// starts a new frame straight away.
module frame_deserializer #(
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter logic [7:0]  FOOTER       = 8'hFF,
  parameter int unsigned NUM_CHANNELS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                din,
  input  logic                      din_valid,
  output logic [8*NUM_CHANNELS-1:0] frame_data,
  output logic                      frame_valid,
  output logic                      frame_error,
  output logic [15:0]               frame_count,
  output logic [7:0]                err_count,
  output logic                      busy
);

  localparam int unsigned ChW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    StHunt        = 2'b00,
    StRecvData    = 2'b01,
    StCheckFooter = 2'b10
  } state_e;

  state_e                    state_q, state_d;
  logic [ChW-1:0]            ch_cnt_q, ch_cnt_d;
  logic [7:0]                stage_q [NUM_CHANNELS];
  logic [8*NUM_CHANNELS-1:0] frame_data_q;
  logic                      frame_valid_q;
  logic                      frame_error_q;
  logic [15:0]               frame_count_q;
  logic [7:0]                err_count_q;

  logic stage_we;
  logic footer_good;
  logic footer_bad;

  // Next-state decode; bytes are only consumed when din_valid is high.
  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    stage_we    = 1'b0;
    footer_good = 1'b0;
    footer_bad  = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (din_valid && din == HEADER) begin
          state_d  = StRecvData;
          ch_cnt_d = '0;
        end
      end
      StRecvData: begin
        // Payload is never compared against HEADER/FOOTER.
        if (din_valid) begin
          stage_we = 1'b1;
          if (ch_cnt_q == LastCh) begin
            state_d  = StCheckFooter;
            ch_cnt_d = '0;
          end else begin
            ch_cnt_d = ch_cnt_q + ChW'(1);
          end
        end
      end
      StCheckFooter: begin
        if (din_valid) begin
          ch_cnt_d = '0;
          if (din == FOOTER) begin
            footer_good = 1'b1;
            state_d     = StHunt;
          end else begin
            footer_bad = 1'b1;
            // A header in the footer slot resyncs onto a new frame.
            state_d    = (din == HEADER) ? StRecvData : StHunt;
          end
        end
      end
      default: begin
        state_d  = StHunt;
        ch_cnt_d = '0;
      end
    endcase
  end

  // FSM state and channel counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      ch_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
    end
  end

  // Staging buffer; contents are irrelevant until a full frame is collected.
  always_ff @(posedge clk) begin
    if (stage_we) begin
      stage_q[ch_cnt_q] <= din;
    end
  end

  // Published payload, status pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      frame_valid_q <= footer_good;
      frame_error_q <= footer_bad;
      if (footer_good) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          frame_data_q[8*k +: 8] <= stage_q[k];
        end
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (footer_bad && err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign busy        = (state_q != StHunt);

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer with default parameters.
module tb_frame_deserializer;

  logic         clk;
  logic         rst;
  logic [7:0]   din;
  logic         din_valid;
  logic [127:0] frame_data;
  logic         frame_valid;
  logic         frame_error;
  logic [15:0]  frame_count;
  logic [7:0]   err_count;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;

  logic [7:0]   pl [16];
  logic [127:0] exp_fd;
  logic [127:0] prev_fd;
  int           v0;
  int           e0;

  frame_deserializer dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .frame_count (frame_count),
    .err_count   (err_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_error) n_err++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one byte for the next posedge.
  task automatic send(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] foot, input int gap);
    send(8'hAA);
    idle(gap);
    for (int k = 0; k < 16; k++) begin
      send(pl[k]);
      idle(gap);
    end
    send(foot);
  endtask

  task automatic build_exp();
    for (int k = 0; k < 16; k++) exp_fd[8*k +: 8] = pl[k];
  endtask

  initial begin
    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;

    // Reset state (din_valid was high during reset and must be ignored).
    check("rst_data", frame_data, 128'd0);
    check("rst_count", {112'd0, frame_count}, 128'd0);
    check("rst_err", {120'd0, err_count}, 128'd0);
    check("rst_valid", {127'd0, frame_valid}, 128'd0);
    check("rst_error", {127'd0, frame_error}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);

    // Good frame 00..0F back to back.
    for (int k = 0; k < 16; k++) pl[k] = 8'(k);
    build_exp();
    send(8'hAA);
    check("busy_after_hdr", {127'd0, busy}, 128'd1);
    for (int k = 0; k < 16; k++) send(pl[k]);
    check("no_early_valid", {127'd0, frame_valid}, 128'd0);
    send(8'hFF);
    check("good_valid", {127'd0, frame_valid}, 128'd1);
    check("good_data", frame_data, exp_fd);
    check("good_count", {112'd0, frame_count}, 128'd1);
    idle(1);
    check("good_valid_drop", {127'd0, frame_valid}, 128'd0);
    check("good_busy_idle", {127'd0, busy}, 128'd0);

    // Same frame with three idle cycles between bytes.
    idle(1);
    v0 = n_valid;
    send_frame(8'hFF, 3);
    idle(2);
    check("gap_data", frame_data, exp_fd);
    check("gap_pulses", 128'(n_valid - v0), 128'd1);
    check("gap_count", {112'd0, frame_count}, 128'd2);

    // Bad footer leaves the published payload untouched.
    prev_fd = exp_fd;
    for (int k = 0; k < 16; k++) pl[k] = 8'h10 + 8'(k);
    send_frame(8'h55, 0);
    check("bad_error", {127'd0, frame_error}, 128'd1);
    check("bad_novalid", {127'd0, frame_valid}, 128'd0);
    check("bad_errcnt", {120'd0, err_count}, 128'd1);
    idle(1);
    check("bad_data_held", frame_data, prev_fd);
    check("bad_busy", {127'd0, busy}, 128'd0);
    check("bad_count_held", {112'd0, frame_count}, 128'd2);

    // Header in the footer slot resyncs onto the following frame.
    idle(1);
    v0 = n_valid;
    e0 = n_err;
    send(8'hAA);
    for (int k = 0; k < 16; k++) send(8'h20 + 8'(k));
    send(8'hAA);
    check("resync_error", {127'd0, frame_error}, 128'd1);
    check("resync_busy", {127'd0, busy}, 128'd1);
    for (int k = 0; k < 16; k++) pl[k] = 8'h30 + 8'(k);
    build_exp();
    for (int k = 0; k < 16; k++) send(pl[k]);
    send(8'hFF);
    idle(2);
    check("resync_data", frame_data, exp_fd);
    check("resync_valids", 128'(n_valid - v0), 128'd1);
    check("resync_errs", 128'(n_err - e0), 128'd1);
    check("resync_errcnt", {120'd0, err_count}, 128'd2);
    check("resync_count", {112'd0, frame_count}, 128'd3);

    // Leading noise, payload containing header/footer values.
    for (int k = 0; k < 16; k++) pl[k] = (k % 3 == 0) ? 8'hAA : (k % 3 == 1) ? 8'hFF : 8'(k);
    build_exp();
    v0 = n_valid;
    send(8'h12);
    send(8'h34);
    check("noise_hunt", {127'd0, busy}, 128'd0);
    send_frame(8'hFF, 0);
    idle(2);
    check("noise_data", frame_data, exp_fd);
    check("noise_valids", 128'(n_valid - v0), 128'd1);
    check("noise_count", {112'd0, frame_count}, 128'd4);

    // Back-to-back frames with no idle cycle between footer and header.
    v0 = n_valid;
    send_frame(8'hFF, 0);
    for (int k = 0; k < 16; k++) pl[k] = 8'hC0 + 8'(k);
    build_exp();
    send_frame(8'hFF, 0);
    idle(2);
    check("b2b_valids", 128'(n_valid - v0), 128'd2);
    check("b2b_data", frame_data, exp_fd);
    check("b2b_count", {112'd0, frame_count}, 128'd6);

    // Reset mid-frame discards the partial frame.
    v0 = n_valid;
    e0 = n_err;
    send(8'hAA);
    for (int k = 0; k < 5; k++) send(8'h50 + 8'(k));
    rst       = 1'b1;
    din       = 8'hFF;
    din_valid = 1'b1;
    idle(1);
    rst       = 1'b0;
    din_valid = 1'b0;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_data", frame_data, 128'd0);
    for (int k = 0; k < 16; k++) pl[k] = 8'h70 + 8'(k);
    build_exp();
    send_frame(8'hFF, 0);
    idle(2);
    check("mid_rst_valids", 128'(n_valid - v0), 128'd1);
    check("mid_rst_errs", 128'(n_err - e0), 128'd0);
    check("mid_rst_count", {112'd0, frame_count}, 128'd1);
    check("mid_rst_errcnt", {120'd0, err_count}, 128'd0);
    check("mid_rst_payload", frame_data, exp_fd);

    // err_count saturates at 255.
    for (int i = 0; i < 256; i++) send_frame(8'h00, 0);
    idle(1);
    check("err_sat", {120'd0, err_count}, 128'd255);
    check("err_sat_data", frame_data, exp_fd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_deserializer.md
FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hAA, meaning the frame start byte.
REQ-002 The block SHALL have parameter FOOTER, default 8'hFF, meaning the frame end byte.
REQ-003 The block SHALL have parameter NUM_CHANNELS, default 16, meaning the payload bytes per frame; legal range 1..256.
REQ-004 The block SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port din  input  8  received byte.
REQ-007 The block SHALL have port din_valid  input  1  din is a valid byte this cycle.
REQ-008 The block SHALL have port frame_data  output  8*NUM_CHANNELS  last good payload; channel k in bits [8k+7:8k].
REQ-009 The block SHALL have port frame_valid  output  1  one-cycle pulse: frame_data was just updated.
REQ-010 The block SHALL have port frame_error  output  1  one-cycle pulse: footer mismatch.
REQ-011 The block SHALL have port frame_count  output  16  good frames received, wrapping.
REQ-012 The block SHALL have port err_count  output  8  footer errors, saturating.
REQ-013 The block SHALL have port busy  output  1  high when state is not HUNT.

Function
REQ-014 The block SHALL implement states HUNT, RECV_DATA and CHECK_FOOTER.
REQ-015 The block SHALL accept a byte only in a cycle with din_valid=1; with din_valid=0, state, counter and buffer hold, with no timeout.
REQ-016 In HUNT, an accepted byte equal to HEADER SHALL move the block to RECV_DATA with the channel counter cleared; any other byte is discarded.
REQ-017 In RECV_DATA, the accepted byte SHALL be written to staging buffer slot ch_cnt, and ch_cnt increments.
REQ-018 In RECV_DATA, the accepted byte with ch_cnt==NUM_CHANNELS-1 SHALL move the block to CHECK_FOOTER with ch_cnt cleared.
REQ-019 Payload bytes SHALL NOT be compared against HEADER or FOOTER; values AA/FF are legal data.
REQ-020 In CHECK_FOOTER, an accepted FOOTER SHALL cause the staging buffer to be copied to frame_data, frame_count to increment, and the block to go to HUNT.
REQ-021 frame_valid SHALL pulse high for exactly the cycle after the footer is accepted, with frame_data already updated in that cycle.
REQ-022 In CHECK_FOOTER, an accepted byte not equal to FOOTER SHALL pulse frame_error the following cycle, increment err_count (holding at 255), and leave frame_data unchanged.
REQ-023 The next state after a footer mismatch SHALL be RECV_DATA with ch_cnt=0 if the mismatched byte equals HEADER (resync), else HUNT.
REQ-024 frame_data SHALL change only on a good footer; a partial or errored frame SHALL never be visible.
REQ-025 frame_count SHALL wrap from 16'hFFFF to 0.
REQ-026 A new HEADER SHALL be accepted in the cycle immediately after a good footer, giving back-to-back frames with no idle cycle.
REQ-027 Latency from footer accept to frame_valid SHALL be 1 cycle; throughput SHALL be one byte per cycle.
REQ-028 The channel counter SHALL be $clog2(NUM_CHANNELS) bits wide, minimum 1.
REQ-029 The block SHALL treat an unreachable state encoding as HUNT on the next cycle.

Reset
REQ-030 With rst=1 at a clock edge, state SHALL become HUNT and ch_cnt 0.
REQ-031 With rst=1 at a clock edge, frame_data, frame_count and err_count SHALL become 0, and frame_valid, frame_error and busy 0.
REQ-032 rst SHALL take priority over din_valid.
REQ-033 rst asserted mid-frame SHALL discard the partial frame, with no frame_valid and no frame_error.
REQ-034 The staging buffer need not be reset.

Verification
REQ-035 Good frame: AA, bytes 00..0F, FF on consecutive cycles -> frame_valid one cycle after FF; frame_data[7:0]=00 and [127:120]=0F; frame_count=1.
REQ-036 Gaps: same frame with din_valid=0 for 3 cycles between each byte -> identical frame_data; frame_valid pulses once.
REQ-037 Bad footer: AA, 16 bytes, 55 -> frame_error pulse; err_count=1; frame_data keeps its prior value; busy=0 afterward.
REQ-038 Resync: AA, 16 bytes, then AA in the footer slot, then 16 bytes, FF -> one frame_error, then one frame_valid carrying the second payload.
REQ-039 Noise and data values: 12, 34, AA, payload containing AA and FF, FF -> garbage ignored; payload captured intact; one frame_valid.
REQ-040 Reset mid-frame: rst after 5 payload bytes, then a full good frame -> only one frame_valid; frame_count=1; err_count=0.
